// File: rtl/busio_pkg.sv
// Shared encodings for the busio_arbiter slice: access sizes, FSM states
// and bus ownership.
package busio_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_MEM   = 1'b1
  } owner_e;

endpackage

// File: rtl/busio_arbiter_if.sv
// Pipeline-side fetch/load-store ports and the external memory bus of the
// arbiter; slave = arbiter view, master = environment (pipeline + memory) view.
interface busio_arbiter_if;
  logic [31:0] fetch_address;
  logic [31:0] fetch_data;
  logic        fetch_ready;

  logic [31:0] mem_address;
  logic [31:0] mem_store_data;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic        mem_load;
  logic        mem_store;
  logic [31:0] mem_load_data;
  logic        mem_ready;
  logic        mem_misaligned;

  logic [31:0] ext_address;
  logic [31:0] ext_write_data;
  logic [3:0]  ext_write_strobe;
  logic        ext_valid;
  logic        ext_ready;
  logic [31:0] ext_read_data;

  modport slave (
    input  fetch_address, mem_address, mem_store_data, mem_size, mem_signed,
           mem_load, mem_store, ext_ready, ext_read_data,
    output fetch_data, fetch_ready, mem_load_data, mem_ready, mem_misaligned,
           ext_address, ext_write_data, ext_write_strobe, ext_valid
  );

  modport master (
    output fetch_address, mem_address, mem_store_data, mem_size, mem_signed,
           mem_load, mem_store, ext_ready, ext_read_data,
    input  fetch_data, fetch_ready, mem_load_data, mem_ready, mem_misaligned,
           ext_address, ext_write_data, ext_write_strobe, ext_valid
  );
endinterface

// File: rtl/busio_lane_format.sv
// Byte-lane steering: store strobes/replicated data, load extraction with
// sign/zero extension, and misalignment detection.
module busio_lane_format
  import busio_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] read_data_i,
  output logic [3:0]  strobe_o,
  output logic [31:0] write_data_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted      = read_data_i >> {addr_lo_i, 3'b000};
    strobe_o     = 4'b1111;
    write_data_o = store_data_i;
    load_data_o  = shifted;
    misaligned_o = 1'b0;
    case (size_i)
      SIZE_BYTE: begin
        strobe_o     = 4'b0001 << addr_lo_i;
        write_data_o = {4{store_data_i[7:0]}};
        load_data_o  = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        strobe_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        write_data_o = {2{store_data_i[15:0]}};
        load_data_o  = {{16{signed_i & shifted[15]}}, shifted[15:0]};
        misaligned_o = addr_lo_i[0];
      end
      SIZE_WORD: misaligned_o = |addr_lo_i;
      default: begin
        strobe_o     = 4'b0000;
        misaligned_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/busio_arbiter.sv
// Shares one single-port memory bus between instruction fetch and load/store.
// Optional single-entry fetch buffer enabled by `define BUSIO_ARB_FETCH_BUFFER_EN.
module busio_arbiter
  import busio_pkg::*;
#(
  parameter int unsigned MEM_BURST_MAX = 4
) (
  input logic            clk,
  input logic            reset,
  busio_arbiter_if.slave bus
);

  localparam int BW = (MEM_BURST_MAX > 0) ? $clog2(MEM_BURST_MAX + 1) : 1;
  localparam logic [BW-1:0] BURST_LIM = BW'(MEM_BURST_MAX);

  state_e      state_q;
  owner_e      owner_q;
  logic [31:0] fetch_addr_q;
  logic [BW-1:0] burst_q, burst_d;
  logic        ext_valid_q;
  logic [31:0] ext_address_q;
  logic [31:0] ext_write_data_q;
  logic [3:0]  ext_write_strobe_q;
  logic [31:0] fetch_data_q;
  logic [31:0] mem_load_data_q;
  logic        mem_misaligned_q;

  logic        mem_req;
  logic        fetch_forced;
  logic        mem_grant;
  logic [3:0]  fmt_strobe;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_load;
  logic        fmt_misaligned;

`ifdef BUSIO_ARB_FETCH_BUFFER_EN
  logic        buf_valid_q;
  logic [31:0] buf_addr_q;
  logic [31:0] buf_data_q;
  logic        buf_hit;
  assign buf_hit = buf_valid_q && (buf_addr_q == bus.fetch_address);
`endif

  // Memory-port inputs are stable for the whole transaction, so the live
  // values drive both the store alignment and the load formatting.
  busio_lane_format u_lane_format (
    .addr_lo_i    (bus.mem_address[1:0]),
    .size_i       (bus.mem_size),
    .signed_i     (bus.mem_signed),
    .store_data_i (bus.mem_store_data),
    .read_data_i  (bus.ext_read_data),
    .strobe_o     (fmt_strobe),
    .write_data_o (fmt_wdata),
    .load_data_o  (fmt_load),
    .misaligned_o (fmt_misaligned)
  );

  assign mem_req      = bus.mem_load | bus.mem_store;
  assign fetch_forced = (MEM_BURST_MAX != 0) && (burst_q == BURST_LIM);
  assign mem_grant    = mem_req && !fetch_forced;

  always_comb begin
    burst_d = burst_q;
    if (MEM_BURST_MAX != 0 && burst_q != BURST_LIM) burst_d = burst_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= IDLE;
      owner_q            <= OWNER_FETCH;
      fetch_addr_q       <= '0;
      burst_q            <= '0;
      ext_valid_q        <= 1'b0;
      ext_address_q      <= '0;
      ext_write_data_q   <= '0;
      ext_write_strobe_q <= '0;
      fetch_data_q       <= '0;
      mem_load_data_q    <= '0;
      mem_misaligned_q   <= 1'b0;
`ifdef BUSIO_ARB_FETCH_BUFFER_EN
      buf_valid_q        <= 1'b0;
      buf_addr_q         <= '0;
      buf_data_q         <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_grant) begin
            owner_q <= OWNER_MEM;
            burst_q <= burst_d;
`ifdef BUSIO_ARB_FETCH_BUFFER_EN
            if (bus.mem_store) buf_valid_q <= 1'b0;
`endif
            if (fmt_misaligned) begin
              mem_misaligned_q <= 1'b1;
              mem_load_data_q  <= '0;
              state_q          <= RESP;
            end else begin
              ext_valid_q        <= 1'b1;
              ext_address_q      <= {bus.mem_address[31:2], 2'b00};
              ext_write_strobe_q <= bus.mem_store ? fmt_strobe : 4'b0000;
              ext_write_data_q   <= bus.mem_store ? fmt_wdata : 32'h0;
              state_q            <= BUS;
            end
          end else begin
            owner_q      <= OWNER_FETCH;
            burst_q      <= '0;
            fetch_addr_q <= bus.fetch_address;
`ifdef BUSIO_ARB_FETCH_BUFFER_EN
            if (!mem_req && buf_hit) begin
              fetch_data_q <= buf_data_q;
              state_q      <= RESP;
            end else begin
              ext_valid_q        <= 1'b1;
              ext_address_q      <= {bus.fetch_address[31:2], 2'b00};
              ext_write_strobe_q <= 4'b0000;
              ext_write_data_q   <= 32'h0;
              state_q            <= BUS;
            end
`else
            ext_valid_q        <= 1'b1;
            ext_address_q      <= {bus.fetch_address[31:2], 2'b00};
            ext_write_strobe_q <= 4'b0000;
            ext_write_data_q   <= 32'h0;
            state_q            <= BUS;
`endif
          end
        end
        BUS: begin
          if (bus.ext_ready) begin
            ext_valid_q <= 1'b0;
            state_q     <= RESP;
            if (owner_q == OWNER_FETCH) begin
              fetch_data_q <= bus.ext_read_data;
`ifdef BUSIO_ARB_FETCH_BUFFER_EN
              buf_valid_q  <= 1'b1;
              buf_addr_q   <= fetch_addr_q;
              buf_data_q   <= bus.ext_read_data;
`endif
            end else if (!bus.mem_store) begin
              mem_load_data_q <= fmt_load;
            end
          end
        end
        RESP: begin
          mem_misaligned_q <= 1'b0;
          state_q          <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A fetch whose address moved on while the bus cycle ran is silently dropped.
  assign bus.fetch_ready      = (state_q == RESP) && (owner_q == OWNER_FETCH) &&
                                (bus.fetch_address == fetch_addr_q);
  assign bus.fetch_data       = fetch_data_q;
  assign bus.mem_ready        = !mem_req || ((state_q == RESP) && (owner_q == OWNER_MEM));
  assign bus.mem_load_data    = mem_load_data_q;
  assign bus.mem_misaligned   = mem_misaligned_q;
  assign bus.ext_valid        = ext_valid_q;
  assign bus.ext_address      = ext_address_q;
  assign bus.ext_write_data   = ext_write_data_q;
  assign bus.ext_write_strobe = ext_write_strobe_q;

endmodule

// File: tb/tb_busio_arbiter.sv
// Self-checking bench for busio_arbiter: directed scenarios plus a randomized
// load/store stream checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_busio_arbiter;

  localparam int MAXB = 2;
  localparam logic [31:0] FA = 32'h0000_1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  busio_arbiter_if bif ();

  busio_arbiter #(.MEM_BURST_MAX(MAXB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  // The pipeline promises stable memory inputs until mem_ready.
  logic        p_act = 1'b0;
  logic [31:0] p_addr, p_data;
  logic [1:0]  p_size;
  logic        p_sg, p_ld, p_st;
  always @(posedge clk) begin
    if (reset) p_act <= 1'b0;
    else begin
      if (p_act && !bif.mem_ready)
        assert ({bif.mem_address, bif.mem_store_data, bif.mem_size, bif.mem_signed,
                 bif.mem_load, bif.mem_store} == {p_addr, p_data, p_size, p_sg, p_ld, p_st})
        else $error("memory-port inputs changed before mem_ready");
      p_act  <= bif.mem_load | bif.mem_store;
      p_addr <= bif.mem_address;
      p_data <= bif.mem_store_data;
      p_size <= bif.mem_size;
      p_sg   <= bif.mem_signed;
      p_ld   <= bif.mem_load;
      p_st   <= bif.mem_store;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- reference arithmetic ----------------
  function automatic bit exp_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [3:0] exp_strobe(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'(1 << (a % 4));
    if (sz == 2'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic sg,
                                           input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> ((a % 4) * 8);
    if (sz == 2'd0) begin
      v = v % 256;
      if (sg && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (sg && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset;
    bif.ext_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic mem_idle;
    bif.mem_load = 1'b0;
    bif.mem_store = 1'b0;
  endtask

  task automatic set_mem(input bit ld, input bit st, input logic [31:0] a, input logic [1:0] sz,
                         input bit sg, input logic [31:0] d);
    bif.mem_load = ld;
    bif.mem_store = st;
    bif.mem_address = a;
    bif.mem_size = sz;
    bif.mem_signed = sg;
    bif.mem_store_data = d;
  endtask

  task automatic new_op;
    int k;
    k = $urandom_range(0, 2);
    set_mem(k != 1, k != 0, 32'h2000 + 32'($urandom_range(0, 255)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
  endtask

  // Acts as the memory slave for one transaction; returns at the RESP negedge.
  task automatic serve(input int waits, input logic [31:0] rd, output logic [31:0] a,
                       output logic [3:0] s, output logic [31:0] wd, output int vcyc,
                       output bit ok);
    int n;
    n = 0; ok = 1'b0; vcyc = 0; a = '0; s = '0; wd = '0;
    while (bif.ext_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bif.ext_valid === 1'b1) begin
      a = bif.ext_address;
      s = bif.ext_write_strobe;
      wd = bif.ext_write_data;
      vcyc = 1;
      for (int k = 0; k < waits; k++) begin
        @(negedge clk);
        if (bif.ext_valid === 1'b1 && bif.ext_address === a) vcyc++;
      end
      bif.ext_read_data = rd;
      bif.ext_ready = 1'b1;
      @(negedge clk);
      bif.ext_ready = 1'b0;
      ok = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    mem_idle();
    bif.fetch_address = 32'h100;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bif.ext_valid, bif.ext_write_strobe, bif.fetch_ready, bif.mem_misaligned} !== 7'd0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0", {bif.ext_valid, bif.ext_write_strobe, bif.fetch_ready, bif.mem_misaligned});
    end
    total++;
    if ({bif.ext_address, bif.ext_write_data, bif.fetch_data, bif.mem_load_data} !== 128'd0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0", {bif.ext_address, bif.ext_write_data, bif.fetch_data, bif.mem_load_data});
    end
    total++;
    if (bif.mem_ready !== 1'b1) begin bad++; $display("FAIL reset_mem_ready got=%b exp=1", bif.mem_ready); end
  endtask

  task automatic test_fetch_wait;
    logic [31:0] a, wd; logic [3:0] s; int vc; bit ok;
    mem_idle();
    bif.fetch_address = 32'h100;
    do_reset();
    serve(2, 32'h00A0_0093, a, s, wd, vc, ok);
    total++;
    if (!ok || a !== 32'h100) begin bad++; $display("FAIL fetch_addr got=%h exp=%h ok=%0d", a, 32'h100, ok); end
    total++;
    if (vc !== 3) begin bad++; $display("FAIL fetch_valid_cycles got=%0d exp=3", vc); end
    total++;
    if (bif.fetch_ready !== 1'b1 || bif.fetch_data !== 32'h00A0_0093) begin
      bad++; $display("FAIL fetch_ready got=%b/%h exp=1/00a00093", bif.fetch_ready, bif.fetch_data);
    end
    total++;
    if (bif.ext_valid !== 1'b0) begin bad++; $display("FAIL fetch_valid_drop got=%b exp=0", bif.ext_valid); end
  endtask

  task automatic test_fetch_buffer;
    int ev, pulses; bit data_ok;
    ev = 0; pulses = 0; data_ok = 1'b1;
    @(negedge clk);
    total++;
    if (bif.fetch_ready !== 1'b0) begin bad++; $display("FAIL fetch_pulse_width got=%b exp=0", bif.fetch_ready); end
    for (int k = 0; k < 6; k++) begin
      if (bif.ext_valid === 1'b1 && bif.ext_address === 32'h100) ev++;
      if (bif.fetch_ready === 1'b1) begin
        pulses++;
        if (bif.fetch_data !== 32'h00A0_0093) data_ok = 1'b0;
      end
      @(negedge clk);
    end
`ifdef BUSIO_ARB_FETCH_BUFFER_EN
    total++;
    if (ev !== 0 || pulses !== 3 || !data_ok) begin
      bad++; $display("FAIL buffer_hit got=ev%0d/p%0d/d%0d exp=ev0/p3/d1", ev, pulses, data_ok);
    end
`else
    total++;
    if (ev == 0 || pulses !== 0) begin
      bad++; $display("FAIL refetch_bus got=ev%0d/p%0d exp=ev>0/p0", ev, pulses);
    end
`endif
  endtask

  task automatic test_load;
    logic [31:0] a, wd; logic [3:0] s; int vc; bit ok;
    bif.fetch_address = 32'h100;
    set_mem(1'b1, 1'b0, 32'h203, 2'd0, 1'b1, 32'h0);
    do_reset();
    serve(0, 32'h80FF_FFFF, a, s, wd, vc, ok);
    total++;
    if (!ok || a !== 32'h200 || s !== 4'h0) begin bad++; $display("FAIL load_bus got=%h/%h exp=200/0", a, s); end
    total++;
    if (bif.mem_ready !== 1'b1 || bif.mem_load_data !== 32'hFFFF_FF80 || bif.fetch_ready !== 1'b0) begin
      bad++; $display("FAIL load_signed got=%b/%h exp=1/ffffff80", bif.mem_ready, bif.mem_load_data);
    end
    bif.mem_signed = 1'b0;
    serve(1, 32'h80FF_FFFF, a, s, wd, vc, ok);
    total++;
    if (!ok || bif.mem_ready !== 1'b1 || bif.mem_load_data !== 32'h0000_0080) begin
      bad++; $display("FAIL load_unsigned got=%b/%h exp=1/00000080", bif.mem_ready, bif.mem_load_data);
    end
    mem_idle();
  endtask

  task automatic test_store;
    logic [31:0] a, wd; logic [3:0] s; int vc; bit ok;
    set_mem(1'b0, 1'b1, 32'h302, 2'd1, 1'b0, 32'h0000_BEEF);
    do_reset();
    serve(1, 32'h1234_5678, a, s, wd, vc, ok);
    total++;
    if (!ok || a !== 32'h300 || s !== 4'b1100 || wd !== 32'hBEEF_BEEF) begin
      bad++; $display("FAIL store_half got=%h/%b/%h exp=300/1100/beefbeef", a, s, wd);
    end
    total++;
    if (bif.mem_ready !== 1'b1 || bif.mem_load_data !== 32'h0) begin
      bad++; $display("FAIL store_resp got=%b/%h exp=1/0", bif.mem_ready, bif.mem_load_data);
    end
    mem_idle();
  endtask

  task automatic test_misaligned;
    logic [31:0] a, wd; logic [3:0] s; int vc; bit ok;
    set_mem(1'b1, 1'b0, 32'h400, 2'd2, 1'b0, 32'h0);
    do_reset();
    serve(0, 32'h1234_5678, a, s, wd, vc, ok);
    total++;
    if (!ok || bif.mem_load_data !== 32'h1234_5678) begin
      bad++; $display("FAIL word_load got=%h exp=12345678", bif.mem_load_data);
    end
    bif.mem_address = 32'h401;
    @(negedge clk);
    total++;
    if (bif.mem_ready !== 1'b0 || bif.mem_misaligned !== 1'b0 || bif.ext_valid !== 1'b0) begin
      bad++; $display("FAIL mis_idle got=%b%b%b exp=000", bif.mem_ready, bif.mem_misaligned, bif.ext_valid);
    end
    @(negedge clk);
    total++;
    if (bif.mem_ready !== 1'b1 || bif.mem_misaligned !== 1'b1 || bif.ext_valid !== 1'b0 ||
        bif.mem_load_data !== 32'h0) begin
      bad++; $display("FAIL mis_resp got=%b%b%b/%h exp=110/0", bif.mem_ready, bif.mem_misaligned,
                      bif.ext_valid, bif.mem_load_data);
    end
    @(negedge clk);
    total++;
    if (bif.mem_misaligned !== 1'b0 || bif.mem_ready !== 1'b0) begin
      bad++; $display("FAIL mis_pulse got=%b/%b exp=0/0", bif.mem_misaligned, bif.mem_ready);
    end
    mem_idle();
  endtask

  task automatic test_redirect;
    logic [31:0] a, wd; logic [3:0] s; int vc, n; bit ok;
    mem_idle();
    bif.fetch_address = 32'h500;
    do_reset();
    n = 0;
    while (bif.ext_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    total++;
    if (bif.ext_valid !== 1'b1 || bif.ext_address !== 32'h500) begin
      bad++; $display("FAIL redirect_first got=%b/%h exp=1/500", bif.ext_valid, bif.ext_address);
    end
    bif.fetch_address = 32'h600;
    @(negedge clk);
    bif.ext_read_data = 32'h1111_1111;
    bif.ext_ready = 1'b1;
    @(negedge clk);
    bif.ext_ready = 1'b0;
    total++;
    if (bif.fetch_ready !== 1'b0) begin bad++; $display("FAIL redirect_drop got=%b exp=0", bif.fetch_ready); end
    serve(0, 32'h2222_2222, a, s, wd, vc, ok);
    total++;
    if (!ok || a !== 32'h600 || bif.fetch_ready !== 1'b1 || bif.fetch_data !== 32'h2222_2222) begin
      bad++; $display("FAIL redirect_refetch got=%h/%b/%h exp=600/1/22222222", a, bif.fetch_ready, bif.fetch_data);
    end
  endtask

  task automatic test_burst_order;
    logic [31:0] a, wd; logic [3:0] s; int vc; bit ok, is_mem, want_mem;
    bif.fetch_address = FA;
    set_mem(1'b1, 1'b0, 32'h2000, 2'd2, 1'b0, 32'h0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      serve(0, $urandom, a, s, wd, vc, ok);
      is_mem = (a == 32'h2000);
      want_mem = (i % (MAXB + 1)) != MAXB;
      total++;
      if (!ok || is_mem !== want_mem) begin
        bad++; $display("FAIL burst_order[%0d] got_mem=%0d exp_mem=%0d addr=%h", i, is_mem, want_mem, a);
      end
    end
    mem_idle();
  endtask

  task automatic test_random;
    logic [31:0] a, wd, rd, last_load; logic [3:0] s; int vc, streak, gap; bit ok, st, mis_seen;
    bif.fetch_address = FA;
    new_op();
    do_reset();
    gap = 1; streak = 0; last_load = 32'h0;
    for (int i = 0; i < 40; ) begin
      rd = $urandom;
      if (streak < MAXB) begin
        streak++;
        st = bif.mem_store;
        if (exp_mis(bif.mem_size, bif.mem_address)) begin
          mis_seen = 1'b0;
          for (int k = 0; k < gap; k++) begin
            if (bif.ext_valid === 1'b1) mis_seen = 1'b1;
            @(negedge clk);
          end
          last_load = 32'h0;
          total++;
          if (mis_seen || bif.ext_valid !== 1'b0 || bif.mem_ready !== 1'b1 ||
              bif.mem_misaligned !== 1'b1 || bif.mem_load_data !== 32'h0) begin
            bad++; $display("FAIL rnd_mis[%0d] got=%b%b%b%b/%h exp=0011/0", i, mis_seen, bif.ext_valid,
                            bif.mem_ready, bif.mem_misaligned, bif.mem_load_data);
          end
        end else begin
          serve($urandom_range(0, 2), rd, a, s, wd, vc, ok);
          total++;
          if (!ok || a !== (bif.mem_address & 32'hFFFF_FFFC) ||
              s !== (st ? exp_strobe(bif.mem_size, bif.mem_address) : 4'h0)) begin
            bad++; $display("FAIL rnd_bus[%0d] got=%h/%b exp=%h/%b", i, a, s, bif.mem_address & 32'hFFFF_FFFC,
                            st ? exp_strobe(bif.mem_size, bif.mem_address) : 4'h0);
          end
          if (st) begin
            total++;
            if (wd !== exp_wdata(bif.mem_size, bif.mem_store_data)) begin
              bad++; $display("FAIL rnd_wdata[%0d] got=%h exp=%h", i, wd, exp_wdata(bif.mem_size, bif.mem_store_data));
            end
          end else begin
            last_load = exp_load(bif.mem_size, bif.mem_signed, bif.mem_address, rd);
          end
          total++;
          if (bif.mem_ready !== 1'b1 || bif.mem_misaligned !== 1'b0 || bif.mem_load_data !== last_load) begin
            bad++; $display("FAIL rnd_resp[%0d] got=%b%b/%h exp=10/%h", i, bif.mem_ready, bif.mem_misaligned,
                            bif.mem_load_data, last_load);
          end
        end
        i++;
        new_op();
      end else begin
        streak = 0;
        serve($urandom_range(0, 2), rd, a, s, wd, vc, ok);
        total++;
        if (!ok || a !== FA || s !== 4'h0 || bif.fetch_ready !== 1'b1 ||
            bif.fetch_data !== rd || bif.mem_ready !== 1'b0) begin
          bad++; $display("FAIL rnd_fetch got=%h/%b/%b/%h exp=%h/0/1/%h", a, s, bif.fetch_ready,
                          bif.fetch_data, FA, rd);
        end
      end
      gap = 2;
    end
    mem_idle();
  endtask

  task automatic test_reset_mid;
    int n;
    mem_idle();
    bif.fetch_address = 32'h100;
    do_reset();
    n = 0;
    while (bif.ext_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    total++;
    if (bif.ext_valid !== 1'b1) begin bad++; $display("FAIL rstmid_bus got=%b exp=1", bif.ext_valid); end
    reset = 1'b1;
    bif.ext_ready = 1'b1;
    bif.ext_read_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bif.ext_ready = 1'b0;
    total++;
    if ({bif.ext_valid, bif.ext_write_strobe, bif.fetch_ready, bif.mem_misaligned} !== 7'd0 ||
        {bif.ext_address, bif.ext_write_data, bif.fetch_data, bif.mem_load_data} !== 128'd0 ||
        bif.mem_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_outputs got=%b%b/%h/%h exp=0/0/0", bif.ext_valid, bif.fetch_ready,
                      bif.fetch_data, bif.ext_address);
    end
    reset = 1'b0;
  endtask

  initial begin
    bif.ext_ready = 1'b0;
    bif.ext_read_data = 32'h0;
    bif.fetch_address = 32'h0;
    set_mem(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    @(negedge clk);
    test_reset();
    test_fetch_wait();
    test_fetch_buffer();
    test_load();
    test_store();
    test_misaligned();
    test_redirect();
    test_burst_order();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
